instr_fetch: RTL
================

# instr_fetch

Instruction fetch unit that produces the instruction stream consumed by the opcode decoder. It owns the fetch PC, issues word reads to instruction memory over a valid/ready request channel, and buffers in-order responses in a 2-entry queue. It presents each instruction with its PC and an illegal-opcode flag to decode under a valid/ready handshake, and accepts redirects from branch/jump resolution.

## Interface
- XLEN, 32, data/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  XLEN  word-aligned fetch address
- imem_rsp_valid  in  1  response valid; responses return in request order
- imem_rsp_data  in  32  instruction word
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode consumes instruction
- inst  out  32  instruction word; opcode = inst[6:0]
- inst_pc  out  XLEN  PC of inst
- inst_illegal  out  1  opcode outside the defined set (OP, OP_IMM, LOAD, STORE, BRANCH, JALR, JAL, AUIPC, LUI) or inst[1:0] != 2'b11
- redirect_valid  in  1  replace fetch PC, flush stream
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored, treated as 0

## Operation
- States: BOOT, RUN, HALT. Reset -> BOOT; BOOT -> RUN after exactly one cycle; RUN -> HALT when an instruction with inst_illegal=1 handshakes; HALT -> RUN only on redirect_valid.
- Counters: O = outstanding requests (0..2), F = queue occupancy (0..2). pop = inst_valid & inst_ready.
- Issue: imem_req_valid = (state==RUN) & !redirect_valid & (O + F - pop < 2). On imem_req_valid & imem_req_ready: push pc into 2-deep tag queue, pc <= pc + 4 (wraps modulo 2^XLEN), O++.
- Response: on imem_rsp_valid with drop==0, pop tag, push {tag, data} into queue, O--. With drop>0, discard, drop--, O--.
- Output: inst_valid = (F>0) & (state!=HALT); inst/inst_pc/inst_illegal are from the queue head; inst_illegal is decoded from the head word.
- Redirect (highest priority): pc <= {redirect_pc[XLEN-1:2],2'b00}; queue and tag queue cleared; drop <= O minus 1 if a response arrives in the same cycle (that response is discarded); no issue in the redirect cycle; state <= RUN. Any pop in the same cycle is a valid consumption.
- Responses never arrive with O==0. This is a protocol violation, and any resulting behaviour is undefined.
- Reset values: imem_req_valid 0, imem_addr RESET_PC, inst_valid 0, inst 32'h0000_0013 (NOP), inst_pc 0, inst_illegal 0, O=F=drop=0, pc=RESET_PC.

## Timing
- First request is driven in the first cycle after BOOT, i.e. cycle 2 after rst rises.
- Request to inst_valid: response cycle + 1, because the queue head is registered.
- With 1-cycle memory and inst_ready held high, sustained throughput is 1 instruction per cycle.
- The queue holding F=2 is the full condition: no issue unless the same cycle pops.
- imem_addr and imem_req_valid are held stable while imem_req_ready=0, unless redirect_valid is asserted, in which case the address changes next cycle.
- Redirect at cycle t: the first request from redirect_pc is driven at t+1, and inst_valid=0 at t+1.
- Reset asserted mid-operation clears all state in one edge. Any late responses arriving while the block is in BOOT are ignored.

## Structure
- Shared defines file holds OP_* opcode constants (shared with decode), NOP encoding, and RESET_PC default.
- Sub-module fetch_queue is a parameterised 2-entry synchronous FIFO with flush. It is instantiated twice: tag queue of XLEN bits, and instruction queue of XLEN+32 bits.
- FSM, counters, drop logic and illegal decode live in instr_fetch.

## Test plan
- Reset release, 1-cycle memory returning 0x00000013 and inst_ready=1 -> requests 0x0, 0x4, 0x8…; inst_valid from cycle 4, one instruction per cycle, inst_pc matching.
- inst_ready=0 for 5 cycles -> exactly 2 queued; imem_req_valid drops; no word lost or duplicated on release.
- Redirect to 0x100 with 2 requests outstanding -> both stale responses discarded; next inst_pc=0x100.
- Response arriving in the same cycle as redirect to 0x203 -> response discarded; fetch from 0x200.
- Head word 0x0000007F -> inst_illegal=1; after handshake, state is HALT and no requests are issued; redirect to 0x40 resumes fetching.
- imem_req_ready stalled for 3 cycles -> address stable; pc at 0xFFFFFFFC wraps to 0x0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode definitions: opcode encodings, NOP, reset PC and fetch FSM encodings.
package instr_fetch_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // Every defined opcode ends in 2'b11, so a bad inst[1:0] also lands in default.
    function automatic logic opcode_illegal(input logic [31:0] word);
        case (word[6:0])
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_OP: opcode_illegal = 1'b0;
            default:                          opcode_illegal = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch unit bus: imem request/response, decode-side instruction stream and redirect input.
interface instr_fetch_if #(
    parameter int XLEN = 32
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // once valid is raised its payload holds until that transfer (a redirect may cancel a
    // pending imem request). Responses carry no ready and arrive in request order.
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_illegal;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_addr, inst_valid, inst, inst_pc, inst_illegal,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc, inst_illegal,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// fetch_queue: 2-entry synchronous FIFO with flush; head is read straight from registers.
module fetch_queue #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    // A push into a full queue is allowed only when the head leaves in the same cycle.
    assign do_pop  = pop & (count != 2'd0);
    assign do_push = push & ((count != 2'd2) | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues imem reads, buffers in-order responses for decode
// and handles redirects, including discarding responses to requests made before them.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus,
    output logic [1:0]    dbg_state
);
    logic [1:0]       state;
    logic [XLEN-1:0]  pc;
    logic [1:0]       outst;
    logic [1:0]       drop;

    logic [1:0]       f_cnt;
    logic [1:0]       tq_cnt;
    logic [XLEN-1:0]  tag_head;
    logic [XLEN+31:0] iq_head;

    logic             pop;
    logic [2:0]       occ;
    logic             issue;
    logic             rsp_seen;
    logic             rsp_accept;
    logic [31:0]      head_word;

    assign pop   = bus.inst_valid & bus.inst_ready;
    assign occ   = {1'b0, outst} + {1'b0, f_cnt} - {2'b00, pop};
    assign issue = bus.imem_req_valid & bus.imem_req_ready;

    // outst is zero in BOOT, so late responses from before a reset are ignored there.
    assign rsp_seen   = bus.imem_rsp_valid & (outst != 2'd0);
    assign rsp_accept = rsp_seen & (drop == 2'd0) & ~bus.redirect_valid & (tq_cnt != 2'd0);

    assign bus.imem_req_valid = (state == ST_RUN) & ~bus.redirect_valid & (occ < 3'd2);
    assign bus.imem_addr      = pc;

    assign head_word        = (f_cnt == 2'd0) ? NOP_INST : iq_head[31:0];
    assign bus.inst_valid   = (f_cnt != 2'd0) & (state != ST_HALT);
    assign bus.inst         = head_word;
    assign bus.inst_pc      = (f_cnt == 2'd0) ? '0 : iq_head[XLEN+31:32];
    assign bus.inst_illegal = opcode_illegal(head_word);
    assign dbg_state        = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_BOOT;
            pc    <= RESET_PC;
            outst <= 2'd0;
            drop  <= 2'd0;
        end else if (bus.redirect_valid) begin
            // Everything still in flight is stale, including a response landing right now.
            state <= ST_RUN;
            pc    <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            outst <= outst - 2'(rsp_seen);
            drop  <= outst - 2'(rsp_seen);
        end else begin
            case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN:  if (pop && bus.inst_illegal) state <= ST_HALT;
                default: state <= state;
            endcase
            if (issue) pc <= pc + XLEN'(4);
            outst <= outst + 2'(issue) - 2'(rsp_seen);
            if (rsp_seen && drop != 2'd0) drop <= drop - 2'd1;
        end
    end

    fetch_queue #(.W(XLEN)) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_valid),
        .push      (issue),
        .push_data (pc),
        .pop       (rsp_accept),
        .head      (tag_head),
        .count     (tq_cnt)
    );

    fetch_queue #(.W(XLEN + 32)) u_inst_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_valid),
        .push      (rsp_accept),
        .push_data ({tag_head, bus.imem_rsp_data}),
        .pop       (pop),
        .head      (iq_head),
        .count     (f_cnt)
    );
endmodule
